// File: rtl/bin_accum_ser_pkg.sv
// Shared constants and state encoding for the binned transform stages.
// Sign-magnitude bin width, bin count and drain index width live here.
package bin_accum_ser_pkg;
    localparam int SM_W  = 12;
    localparam int NBINS = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;
endpackage

// File: rtl/sm_to_tc.sv
// Sign-magnitude bin value to sign-extended two's complement.
// Negative zero falls out as zero because -0 == 0.
module sm_to_tc
    import bin_accum_ser_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic [SM_W-1:0]  sm_i,
    output logic [ACC_W-1:0] tc_o
);
    logic [ACC_W-1:0] mag_w;

    assign mag_w = ACC_W'(sm_i[SM_W-2:0]);
    assign tc_o  = sm_i[SM_W-1] ? (~mag_w + ACC_W'(1)) : mag_w;
endmodule

// File: rtl/bin_accum_ser.sv
// Frame accumulator over 8 sign-magnitude bins with saturating sums,
// drained one bin per beat over a valid/ready output stream.
module bin_accum_ser
    import bin_accum_ser_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [SM_W-1:0]  I0,
    input  logic [SM_W-1:0]  I1,
    input  logic [SM_W-1:0]  I2,
    input  logic [SM_W-1:0]  I3,
    input  logic [SM_W-1:0]  I4,
    input  logic [SM_W-1:0]  I5,
    input  logic [SM_W-1:0]  I6,
    input  logic [SM_W-1:0]  I7,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [ACC_W-1:0] OUT_DATA,
    output logic [IDX_W-1:0] OUT_IDX,
    output logic             OUT_LAST,
    output logic             OVF
);
    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBINS - 1);
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q [NBINS];
    logic [ACC_W-1:0] acc_d [NBINS];
    logic             ovf_q, ovf_d;

    logic [SM_W-1:0]  in_w  [NBINS];
    logic [ACC_W-1:0] tc_w  [NBINS];
    logic [ACC_W:0]   sum_w [NBINS];
    logic [ACC_W-1:0] sat_w [NBINS];
    logic [NBINS-1:0] hit_w;

    assign in_w[0] = I0;
    assign in_w[1] = I1;
    assign in_w[2] = I2;
    assign in_w[3] = I3;
    assign in_w[4] = I4;
    assign in_w[5] = I5;
    assign in_w[6] = I6;
    assign in_w[7] = I7;

    // One extra sum bit exposes overflow as a mismatch of the top two bits.
    for (genvar g = 0; g < NBINS; g++) begin : g_bin
        sm_to_tc #(.ACC_W(ACC_W)) u_cvt (
            .sm_i (in_w[g]),
            .tc_o (tc_w[g])
        );
        assign sum_w[g] = {acc_q[g][ACC_W-1], acc_q[g]}
                        + {tc_w[g][ACC_W-1], tc_w[g]};
        assign hit_w[g] = sum_w[g][ACC_W] ^ sum_w[g][ACC_W-1];
        assign sat_w[g] = !hit_w[g] ? sum_w[g][ACC_W-1:0]
                        : (sum_w[g][ACC_W] ? SAT_MIN : SAT_MAX);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ACCUM: begin
                if (IN_VALID) begin
                    acc_d = sat_w;
                    ovf_d = ovf_q | (|hit_w);
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            DRAIN: begin
                if (OUT_READY) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ACCUM;
                        for (int n = 0; n < NBINS; n++) begin
                            acc_d[n] = '0;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            for (int n = 0; n < NBINS; n++) begin
                acc_q[n] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
        end
    end

    assign IN_READY  = (state_q == ACCUM);
    assign OUT_VALID = (state_q == DRAIN);
    assign OUT_DATA  = OUT_VALID ? acc_q[idx_q] : '0;
    assign OUT_IDX   = OUT_VALID ? idx_q : '0;
    assign OUT_LAST  = OUT_VALID && (idx_q == LAST_IDX);
    assign OVF       = ovf_q;
endmodule

// File: tb/tb_bin_accum_ser.sv
// Directed bench for bin_accum_ser: a 16-bit and a 12-bit accumulator
// instance share one stimulus stream.
module tb_bin_accum_ser;
    logic        CLK;
    logic        RESET;
    logic        IN_VALID;
    logic        OUT_READY;
    logic [11:0] I0, I1, I2, I3, I4, I5, I6, I7;

    logic        rdy16, val16, last16, ovf16;
    logic [15:0] dat16;
    logic [2:0]  idx16;
    logic        rdy12, val12, last12, ovf12;
    logic [11:0] dat12;
    logic [2:0]  idx12;

    int n_tests = 0;
    int n_fail  = 0;

    bin_accum_ser u16 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy16),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .I4(I4), .I5(I5), .I6(I6), .I7(I7),
        .OUT_VALID(val16), .OUT_READY(OUT_READY), .OUT_DATA(dat16),
        .OUT_IDX(idx16), .OUT_LAST(last16), .OVF(ovf16)
    );

    bin_accum_ser #(.FRAME_LEN(8), .ACC_W(12)) u12 (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(rdy12),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .I4(I4), .I5(I5), .I6(I6), .I7(I7),
        .OUT_VALID(val12), .OUT_READY(OUT_READY), .OUT_DATA(dat12),
        .OUT_IDX(idx12), .OUT_LAST(last12), .OVF(ovf12)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [11:0] v [8]);
        {I0, I1, I2, I3} = {v[0], v[1], v[2], v[3]};
        {I4, I5, I6, I7} = {v[4], v[5], v[6], v[7]};
        IN_VALID = 1'b1;
        repeat (8) step();
        IN_VALID = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) step();
        n_tests++;
        if ({val16, dat16, idx16, last16, ovf16, rdy16} !==
            {1'b0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset16: v=%0b d=%0d i=%0d l=%0b o=%0b r=%0b want 0/0/0/0/0/1",
                     val16, dat16, idx16, last16, ovf16, rdy16);
        end
        n_tests++;
        if ({val12, dat12, idx12, last12, ovf12, rdy12} !==
            {1'b0, 12'd0, 3'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset12: v=%0b d=%0d i=%0d l=%0b o=%0b r=%0b want 0/0/0/0/0/1",
                     val12, dat12, idx12, last12, ovf12, rdy12);
        end
        RESET = 1'b0;
    endtask

    task automatic test_frame_sum();
        int exp [8] = '{0, 80, 0, -80, 0, -80, 0, 80};
        send_frame('{12'h000, 12'h00A, 12'h000, 12'h80A,
                     12'h000, 12'h80A, 12'h000, 12'h00A});
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val16, idx16, last16, dat16} !==
                {1'b1, 3'(i), (i == 7), 16'(exp[i])}) begin
                n_fail++;
                $display("FAIL frame_beat%0d: v=%0b idx=%0d last=%0b data=%0d want idx=%0d data=%0d",
                         i, val16, idx16, last16, $signed(dat16), i, exp[i]);
            end
            step();
        end
        n_tests++;
        if ({val16, rdy16} !== 2'b01) begin
            n_fail++;
            $display("FAIL frame_end: valid=%0b ready=%0b want 0 1", val16, rdy16);
        end
    endtask

    task automatic test_neg_zero();
        send_frame('{12'h800, 12'h800, 12'h800, 12'h800,
                     12'h800, 12'h800, 12'h800, 12'h800});
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val16, idx16, dat16} !== {1'b1, 3'(i), 16'd0}) begin
                n_fail++;
                $display("FAIL negzero_beat%0d: v=%0b idx=%0d data=%0d want 0",
                         i, val16, idx16, $signed(dat16));
            end
            step();
        end
        n_tests++;
        if ({ovf16, ovf12} !== 2'b00) begin
            n_fail++;
            $display("FAIL negzero_ovf: ovf16=%0b ovf12=%0b want 0 0", ovf16, ovf12);
        end
    endtask

    task automatic test_backpressure();
        send_frame('{12'd1, 12'd2, 12'd3, 12'd4, 12'd5, 12'd6, 12'd7, 12'd8});
        repeat (2) step();
        OUT_READY = 1'b0;
        IN_VALID  = 1'b1;
        {I0, I1, I2, I3} = {4{12'h155}};
        {I4, I5, I6, I7} = {4{12'h155}};
        for (int c = 0; c < 4; c++) begin
            n_tests++;
            if ({val16, idx16, dat16, last16, rdy16} !==
                {1'b1, 3'd2, 16'd24, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: v=%0b idx=%0d data=%0d last=%0b rdy=%0b want 1 2 24 0 0",
                         c, val16, idx16, $signed(dat16), last16, rdy16);
            end
            if (c < 3) step();
        end
        OUT_READY = 1'b1;
        IN_VALID  = 1'b0;
        for (int i = 2; i < 8; i++) begin
            n_tests++;
            if ({val16, idx16, dat16} !== {1'b1, 3'(i), 16'(8 * (i + 1))}) begin
                n_fail++;
                $display("FAIL bp_beat%0d: v=%0b idx=%0d data=%0d want %0d",
                         i, val16, idx16, $signed(dat16), 8 * (i + 1));
            end
            step();
        end
        send_frame('{12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1});
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val16, idx16, dat16} !== {1'b1, 3'(i), 16'd8}) begin
                n_fail++;
                $display("FAIL bp_next%0d: v=%0b idx=%0d data=%0d want 8",
                         i, val16, idx16, $signed(dat16));
            end
            step();
        end
    endtask

    task automatic test_saturation();
        int exp12 [8] = '{2047, -2048, 0, 0, 0, 0, 0, 0};
        int exp16 [8] = '{16376, -16376, 0, 0, 0, 0, 0, 0};
        send_frame('{12'h7FF, 12'hFFF, 12'h000, 12'h000,
                     12'h000, 12'h000, 12'h000, 12'h000});
        n_tests++;
        if ({ovf12, ovf16} !== 2'b10) begin
            n_fail++;
            $display("FAIL sat_ovf: ovf12=%0b ovf16=%0b want 1 0", ovf12, ovf16);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val12, idx12, dat12, dat16} !==
                {1'b1, 3'(i), 12'(exp12[i]), 16'(exp16[i])}) begin
                n_fail++;
                $display("FAIL sat_beat%0d: v=%0b idx=%0d d12=%0d d16=%0d want %0d %0d",
                         i, val12, idx12, $signed(dat12), $signed(dat16),
                         exp12[i], exp16[i]);
            end
            step();
        end
        send_frame('{12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1});
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val12, idx12, dat12, ovf12} !== {1'b1, 3'(i), 12'd8, 1'b1}) begin
                n_fail++;
                $display("FAIL sat_next%0d: v=%0b idx=%0d d12=%0d ovf=%0b want 8 1",
                         i, val12, idx12, $signed(dat12), ovf12);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_drain();
        send_frame('{12'd9, 12'd9, 12'd9, 12'd9, 12'd9, 12'd9, 12'd9, 12'd9});
        repeat (4) step();
        n_tests++;
        if ({val16, idx16} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL rst_pre: v=%0b idx=%0d want 1 4", val16, idx16);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_tests++;
        if ({val16, val12, dat16, idx16, rdy16, ovf12} !==
            {1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: v16=%0b v12=%0b d=%0d i=%0d r=%0b ovf12=%0b want 0 0 0 0 1 0",
                     val16, val12, dat16, idx16, rdy16, ovf12);
        end
        send_frame('{12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1, 12'd1});
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if ({val16, idx16, last16, dat16} !==
                {1'b1, 3'(i), (i == 7), 16'd8}) begin
                n_fail++;
                $display("FAIL rst_after%0d: v=%0b idx=%0d last=%0b data=%0d want 8",
                         i, val16, idx16, last16, $signed(dat16));
            end
            step();
        end
    endtask

    initial begin
        RESET     = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        {I0, I1, I2, I3, I4, I5, I6, I7} = '0;
        test_reset();
        test_frame_sum();
        test_neg_zero();
        test_backpressure();
        test_saturation();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
